// File: rtl/digit_scoreboard_ctrl_pkg.sv
// Shared types and constants for the digit scoreboard controller:
// update-FSM states, the BCD digit type and the blank-digit code.
package digit_scoreboard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESCALE,
        ST_INC
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_BLANK = 4'hF;

    // Wide enough to address up to eight digits.
    localparam int PTR_W = 3;

endpackage

// File: rtl/bcd_digit_inc.sv
// Single-digit BCD incrementer. Any value of 9 or above (including invalid
// nibbles) wraps to 0 with a carry, so a corrupted digit self-heals.
module bcd_digit_inc
    import digit_scoreboard_ctrl_pkg::*;
(
    input  bcd_t din,
    output bcd_t dout,
    output logic carry
);

    always_comb begin
        if (din >= 4'd9) begin
            dout  = 4'd0;
            carry = 1'b1;
        end else begin
            dout  = din + 4'd1;
            carry = 1'b0;
        end
    end

endmodule

// File: rtl/digit_scoreboard_ctrl.sv
// N-digit BCD score counter with tear-free once-per-frame updates and a
// 1-clk registered digit/line/col display path. Optional leading-zero
// blanking is enabled by defining DIGIT_LEADING_ZERO_BLANK_EN.
module digit_scoreboard_ctrl
    import digit_scoreboard_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int FRAME_DIV  = 60,
    parameter int FRAME_LINE = 240,
    parameter int ROW_BAND   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8:0]              hpos,
    input  logic [8:0]              vpos,
    input  logic                    run,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic                    load_ready,
    output logic [3:0]              digit,
    output logic [2:0]              line,
    output logic [2:0]              col,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [7:0]       PRESC_INIT = 8'(FRAME_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_DIGITS - 1);

    state_t                  state;
    logic [4*NUM_DIGITS-1:0] counter;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    shadow_full;
    logic [7:0]              prescaler;
    logic [PTR_W-1:0]        ptr;

    logic                    frame_event;
    logic                    load_accept;
    logic [3:0]              idx;
    bcd_t                    disp [NUM_DIGITS];
    bcd_t                    digit_next;
    bcd_t                    cur_digit;
    bcd_t                    inc_digit;
    logic                    inc_carry;

    assign frame_event = (hpos == 9'd0) && (vpos == 9'(FRAME_LINE));
    assign load_ready  = ~shadow_full;
    assign load_accept = load_valid && load_ready;
    assign busy        = (state != ST_IDLE);
    assign idx         = hpos[7:4];

`ifdef DIGIT_LEADING_ZERO_BLANK_EN
    always_comb begin : blank_leading
        logic zero_above;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            disp[i] = counter[4*i +: 4];
            if (i > 0 && zero_above && counter[4*i +: 4] == 4'd0)
                disp[i] = DIGIT_BLANK;
            zero_above = zero_above && (counter[4*i +: 4] == 4'd0);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            disp[i] = counter[4*i +: 4];
    end
`endif

    // Leftmost screen position (idx 0) shows the most significant digit.
    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        digit_next = DIGIT_BLANK;
        if (vpos[8:5] == 4'(ROW_BAND)) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (idx == 4'(NUM_DIGITS - 1 - i))
                    digit_next = disp[i];
        end
    end

    always_comb begin
        cur_digit = counter[3:0];
        for (int i = 0; i < NUM_DIGITS; i++)
            if (ptr == PTR_W'(i))
                cur_digit = counter[4*i +: 4];
    end

    bcd_digit_inc u_inc (
        .din   (cur_digit),
        .dout  (inc_digit),
        .carry (inc_carry)
    );

    // NOTE: the shadow data needs no reset; shadow_full alone says whether it
    // holds anything meaningful.
    always_ff @(posedge clk) begin
        if (load_accept)
            shadow <= load_value;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            counter     <= '0;
            shadow_full <= 1'b0;
            prescaler   <= PRESC_INIT;
            ptr         <= '0;
            digit       <= DIGIT_BLANK;
            line        <= '0;
            col         <= '0;
            overflow    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge state.
            digit    <= digit_next;
            line     <= vpos[4:2];
            col      <= hpos[3:1];
            overflow <= 1'b0;

            if (load_accept)
                shadow_full <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (frame_event) begin
                        if (shadow_full)
                            state <= ST_LOAD;
                        else if (run)
                            state <= ST_PRESCALE;
                    end
                end
                ST_LOAD: begin
                    counter     <= shadow;
                    shadow_full <= 1'b0;
                    prescaler   <= PRESC_INIT;
                    state       <= ST_IDLE;
                end
                ST_PRESCALE: begin
                    if (prescaler == 8'd0) begin
                        prescaler <= PRESC_INIT;
                        ptr       <= '0;
                        state     <= ST_INC;
                    end else begin
                        prescaler <= prescaler - 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                ST_INC: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        if (ptr == PTR_W'(i))
                            counter[4*i +: 4] <= inc_digit;
                    if (!inc_carry) begin
                        state <= ST_IDLE;
                    end else if (ptr == PTR_LAST) begin
                        overflow <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        ptr <= ptr + PTR_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scoreboard_ctrl.sv
// Self-checking bench for digit_scoreboard_ctrl: a display vector table plus
// frame-level sequences for load, increment, overflow and reset corner cases.
module tb_digit_scoreboard_ctrl;

    localparam int NUM_DIGITS = 4;
    localparam int FRAME_DIV  = 2;
    localparam int FRAME_LINE = 240;
    localparam int ROW_BAND   = 0;
    localparam int WINDOW     = 12;

`ifdef DIGIT_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] Z_HI = 4'hF;
`else
    localparam logic [3:0] Z_HI = 4'h0;
`endif

    logic        clk;
    logic        reset;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        run;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic [3:0]  digit;
    logic [2:0]  line;
    logic [2:0]  col;
    logic        overflow;
    logic        busy;

    digit_scoreboard_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .FRAME_DIV  (FRAME_DIV),
        .FRAME_LINE (FRAME_LINE),
        .ROW_BAND   (ROW_BAND)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .run        (run),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .digit      (digit),
        .line       (line),
        .col        (col),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] hpos;
        logic [8:0] vpos;
        logic [3:0] exp_digit;
    } disp_vec_t;

    typedef struct {
        logic [3:0] digit;
        logic [2:0] line;
        logic [2:0] col;
    } disp_exp_t;

    disp_exp_t sb_q[$];
    disp_vec_t table1[9];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_disp(input logic [15:0] value, input int n);
        logic [15:0] sh;
        sh = value >> (4 * n);
`ifdef DIGIT_LEADING_ZERO_BLANK_EN
        if (n > 0 && sh == 16'h0)
            return 4'hF;
`endif
        return sh[3:0];
    endfunction

    task automatic idle_beam();
        hpos = 9'd100;
        vpos = 9'd250;
    endtask

    // Drive one beam position, push the expectation, pop and compare one clk later.
    task automatic show(input string name, input logic [8:0] h, input logic [8:0] v, input logic [3:0] exp_d);
        disp_exp_t e;
        hpos    = h;
        vpos    = v;
        e.digit = exp_d;
        e.line  = v[4:2];
        e.col   = h[3:1];
        sb_q.push_back(e);
        step();
        e = sb_q.pop_front();
        check({name, ".digit"}, 32'(digit), 32'(e.digit));
        check({name, ".line"},  32'(line),  32'(e.line));
        check({name, ".col"},   32'(col),   32'(e.col));
    endtask

    task automatic read_value(input string name, input logic [15:0] value);
        for (int i = 0; i < NUM_DIGITS; i++)
            show($sformatf("%s.pos%0d", name, i), 9'(i * 16 + (i * 5) % 16),
                 9'(ROW_BAND * 32 + i * 7), exp_disp(value, NUM_DIGITS - 1 - i));
        idle_beam();
    endtask

    // One frame event followed by a fixed observation window.
    task automatic frame(output int busy_cnt, output int ovf_cnt);
        hpos = 9'd0;
        vpos = 9'(FRAME_LINE);
        step();
        idle_beam();
        busy_cnt = 0;
        ovf_cnt  = 0;
        for (int k = 0; k < WINDOW; k++) begin
            if (busy)     busy_cnt++;
            if (overflow) ovf_cnt++;
            step();
        end
        check("frame.busy_settled", 32'(busy), 32'd0);
    endtask

    task automatic load(input string name, input logic [15:0] value);
        check({name, ".ready_before"}, 32'(load_ready), 32'd1);
        load_value = value;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check({name, ".ready_after"}, 32'(load_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int b;
        int o;

        reset      = 1'b1;
        run        = 1'b0;
        load_valid = 1'b0;
        load_value = 16'h0;
        idle_beam();
        step();
        step();
        check("rst.load_ready", 32'(load_ready), 32'd1);
        check("rst.digit",      32'(digit),      32'hF);
        check("rst.line",       32'(line),       32'd0);
        check("rst.col",        32'(col),        32'd0);
        check("rst.overflow",   32'(overflow),   32'd0);
        check("rst.busy",       32'(busy),       32'd0);
        reset = 1'b0;

        // Test 1: counter 0, beam sweep
        table1[0] = '{9'd0,   9'd0,   Z_HI};
        table1[1] = '{9'd17,  9'd5,   Z_HI};
        table1[2] = '{9'd40,  9'd31,  Z_HI};
        table1[3] = '{9'd63,  9'd12,  4'h0};
        table1[4] = '{9'd64,  9'd0,   4'hF};
        table1[5] = '{9'd200, 9'd3,   4'hF};
        table1[6] = '{9'd10,  9'd32,  4'hF};
        table1[7] = '{9'd30,  9'd255, 4'hF};
        table1[8] = '{9'd511, 9'd20,  4'hF};
        for (int i = 0; i < 9; i++)
            show($sformatf("t1.vec%0d", i), table1[i].hpos, table1[i].vpos, table1[i].exp_digit);
        idle_beam();

        // Test 2: six frames at FRAME_DIV=2 give three increments
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            frame(b, o);
            check($sformatf("t2.busy%0d", k), 32'(b), (k % 2 == 1) ? 32'd2 : 32'd1);
            check($sformatf("t2.ovf%0d", k),  32'(o), 32'd0);
        end
        read_value("t2", 16'h0003);
        show("t2.h48", 9'd48, 9'd0,  4'h3);
        show("t2.h63", 9'd63, 9'd31, 4'h3);
        idle_beam();

        // Test 3: load 0999, commit, then ripple to 1000
        load("t3.load", 16'h0999);
        frame(b, o);
        check("t3.commit_busy", 32'(b), 32'd1);
        check("t3.ready_back",  32'(load_ready), 32'd1);
        read_value("t3.commit", 16'h0999);
        frame(b, o);
        check("t3.presc_busy", 32'(b), 32'd1);
        read_value("t3.hold", 16'h0999);
        frame(b, o);
        check("t3.inc_busy", 32'(b), 32'd5);
        check("t3.inc_ovf",  32'(o), 32'd0);
        read_value("t3.inc", 16'h1000);

        // Test 4: 9999 wraps with a single overflow pulse
        load("t4.load", 16'h9999);
        frame(b, o);
        read_value("t4.commit", 16'h9999);
        frame(b, o);
        frame(b, o);
        check("t4.inc_busy", 32'(b), 32'd5);
        check("t4.ovf_cnt",  32'(o), 32'd1);
        read_value("t4.wrap", 16'h0000);

        // Test 5: load_valid held across two requests
        run        = 1'b0;
        load_value = 16'h1234;
        load_valid = 1'b1;
        step();
        check("t5.ready_drop", 32'(load_ready), 32'd0);
        load_value = 16'h5678;
        step();
        step();
        check("t5.ready_wait", 32'(load_ready), 32'd0);
        hpos = 9'd0;
        vpos = 9'(FRAME_LINE);
        step();
        idle_beam();
        check("t5.load_busy",  32'(busy),       32'd1);
        check("t5.load_ready", 32'(load_ready), 32'd0);
        step();
        check("t5.ready_back", 32'(load_ready), 32'd1);
        step();
        check("t5.second_acc", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        read_value("t5.first", 16'h1234);
        frame(b, o);
        read_value("t5.second", 16'h5678);

        // Load accepted in the frame-event cycle waits for the next frame
        load_value = 16'h0042;
        load_valid = 1'b1;
        hpos = 9'd0;
        vpos = 9'(FRAME_LINE);
        check("sim.ready", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        idle_beam();
        check("sim.busy",  32'(busy),       32'd0);
        check("sim.ready", 32'(load_ready), 32'd0);
        read_value("sim.unchanged", 16'h5678);
        frame(b, o);
        check("sim.commit_busy", 32'(b), 32'd1);
        read_value("sim.commit", 16'h0042);

        // Test 6: reset in the middle of INC discards counter and shadow
        load("t6.load", 16'h0999);
        frame(b, o);
        run = 1'b1;
        frame(b, o);
        check("t6.presc_busy", 32'(b), 32'd1);
        hpos = 9'd0;
        vpos = 9'(FRAME_LINE);
        step();
        idle_beam();
        check("t6.prescale", 32'(busy), 32'd1);
        load_value = 16'h7777;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("t6.inc_busy",   32'(busy),       32'd1);
        check("t6.shadow_acc", 32'(load_ready), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("t6.rst_busy",  32'(busy),       32'd0);
        check("t6.rst_ready", 32'(load_ready), 32'd1);
        check("t6.rst_digit", 32'(digit),      32'hF);
        check("t6.rst_ovf",   32'(overflow),   32'd0);
        reset = 1'b0;
        run   = 1'b0;
        read_value("t6.after_rst", 16'h0000);
        frame(b, o);
        check("t6.no_commit", 32'(b), 32'd0);
        read_value("t6.discarded", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
